hilo_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, in the EX stage directly downstream of the ALU operand-select stage. It consumes the two 32-bit selected operands alongside the ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide run over multiple cycles. `busy` lets hazard logic stall MFHI/MFLO and back-to-back mult/div until the result is ready.

---
 rtl/hilo_muldiv.sv | 151 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// ============================================================================
//  Module   : hilo_muldiv
//  Purpose  : Iterative 32-bit multiply/divide unit with HI/LO registers
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic [64:0] acc;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        sign_a;
    logic        sign_b;
    logic        is_div;
    logic        div0;

    logic        idle_start;
    logic        accept;
    logic        op_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [64:0] mul_step;
    logic [32:0] div_rem_sh;
    logic [33:0] div_trial;
    logic [64:0] div_step;
    logic [63:0] prod_fix;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    assign busy       = (state != IDLE);
    assign idle_start = (state == IDLE) && start && !cancel;
    assign accept     = idle_start && !op[2];
    // MULT (0) and DIV (2) are the signed codes among 0..3
    assign op_signed  = !op[2] && !op[0];
    assign abs_a      = (op_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign abs_b      = (op_signed && src_b[31]) ? (32'd0 - src_b) : src_b;

    // Shift-add step: acc = {carry, P_hi, P_lo}, multiplicand held in opa
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
    assign mul_step = {1'b0, mul_sum, acc[31:1]};

    // Restoring step: acc = {R[32:0], Q[31:0]}, divisor held in opb
    assign div_rem_sh = {acc[63:32], acc[31]};
    assign div_trial  = {1'b0, div_rem_sh} - {2'b00, opb};
    assign div_step   = div_trial[33] ? {div_rem_sh, acc[30:0], 1'b0}
                                      : {div_trial[32:0], acc[30:0], 1'b1};

    assign prod_fix = (sign_a ^ sign_b) ? (64'd0 - acc[63:0]) : acc[63:0];

    always_comb begin
        fix_hi = prod_fix[63:32];
        fix_lo = prod_fix[31:0];
        if (is_div) begin
            if (div0) begin
                // Rebuild the original dividend from its magnitude and sign
                fix_hi = sign_a ? (32'd0 - opa) : opa;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];
                fix_lo = (sign_a ^ sign_b) ? (32'd0 - acc[31:0]) : acc[31:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cancel) state_next = IDLE;
                     else if (count == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 5'd0;
            acc    <= 65'd0;
            opa    <= 32'd0;
            opb    <= 32'd0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            done <= (state == FIX) && !cancel;

            if (state == CALC && !cancel) count <= count + 5'd1;
            else                          count <= 5'd0;

            if (accept) begin
                opa    <= abs_a;
                opb    <= abs_b;
                sign_a <= op_signed && src_a[31];
                sign_b <= op_signed && src_b[31];
                is_div <= op[1];
                div0   <= op[1] && (src_b == 32'd0);
                acc    <= {33'd0, (op[1] ? abs_a : abs_b)};
            end else if (state == CALC && !cancel) begin
                acc <= is_div ? div_step : mul_step;
            end

            if (state == FIX && !cancel) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else if (idle_start && op == OP_MTHI) begin
                hi <= src_a;
            end else if (idle_start && op == OP_MTLO) begin
                lo <= src_a;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv.
`timescale 1ns/1ps
`default_nettype none

module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int bcyc;
    int dcnt;

    hilo_muldiv dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Issue an op, then watch a bounded window counting busy and done cycles
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int bc, output int dc);
        issue(o, a, b);
        bc = 0; dc = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) dc++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_done", {31'd0, done}, 32'h0);
        rst_n = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bcyc, dcnt);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        check("multu_busy_cycles", bcyc, 33);
        check("multu_done_pulses", dcnt, 1);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, bcyc, dcnt);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);

        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, bcyc, dcnt);
        check("mult_min_hi", hi, 32'h4000_0000);
        check("mult_min_lo", lo, 32'h0);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, bcyc, dcnt);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);

        run_op(3'd3, 32'd7, 32'd2, bcyc, dcnt);
        check("divu_hi", hi, 32'd1);
        check("divu_lo", lo, 32'd3);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bcyc, dcnt);
        check("div_ovf_hi", hi, 32'h0);
        check("div_ovf_lo", lo, 32'h8000_0000);

        run_op(3'd3, 32'd5, 32'd0, bcyc, dcnt);
        check("div0_hi", hi, 32'd5);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_busy_cycles", bcyc, 33);
        check("div0_done_pulses", dcnt, 1);

        issue(3'd4, 32'h1234_5678, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'h0);
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy_after", {31'd0, busy}, 32'h0);
        check("mthi_done", {31'd0, done}, 32'h0);

        // Reserved op must leave HI/LO alone
        issue(3'd6, 32'hAAAA_5555, 32'd0);
        @(negedge clk);
        check("rsvd_hi", hi, 32'h1234_5678);
        check("rsvd_busy", {31'd0, busy}, 32'h0);

        // DIVU 100/3 with an MTLO request arriving mid-flight
        issue(3'd3, 32'd100, 32'd3);
        repeat (4) @(negedge clk);
        op = 3'd5; src_a = 32'hDEAD_BEEF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("ignored_mtlo_lo", lo, 32'hFFFF_FFFF);
        check("calc_hi_stable", hi, 32'h1234_5678);
        check("ignored_mtlo_busy", {31'd0, busy}, 32'h1);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("divu100_hi", hi, 32'd1);
        check("divu100_lo", lo, 32'd33);
        check("divu100_done", dcnt, 1);

        // Cancel a MULTU part way through
        issue(3'd1, 32'd2, 32'd3);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", {31'd0, busy}, 32'h0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("cancel_done", dcnt, 0);
        check("cancel_hi", hi, 32'd1);
        check("cancel_lo", lo, 32'd33);

        // Asynchronous reset mid-operation
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'h0);
        check("arst_done", {31'd0, done}, 32'h0);
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd1, 32'd6, 32'd7, bcyc, dcnt);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd42);
        check("post_rst_busy_cycles", bcyc, 33);
        check("post_rst_done", dcnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
